// File: rtl/restoring_divider.sv
// restoring_divider: unsigned sequential restoring divider, one quotient
// bit per clock, fixed latency of WIDTH iterations (divisor 0 included).
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, accepted when not busy (IDLE or DONE)
//   dividend     unsigned dividend, latched on an accepted start
//   divisor      unsigned divisor, latched on an accepted start
//   busy         high while iterating (CALC)
//   done         one-cycle pulse, results valid (DONE)
//   quotient     unsigned quotient (all ones for divide by zero)
//   remainder    unsigned remainder (dividend for divide by zero)
//   div_by_zero  accepted divisor was zero
module restoring_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);
   localparam int NG = WIDTH / 4;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] dvd_q;
   logic [WIDTH-1:0] dvs_q;

   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] gen;
   logic [WIDTH-1:0] prop;
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] diff;
   logic             no_borrow;
   logic [WIDTH-1:0] rem_nx;
   logic [WIDTH-1:0] dvd_nx;
   logic             accept;
   logic             last;

   // {partial remainder, dividend} shifted left by one; the MSB of the
   // dividend register moves into the WIDTH+1-bit partial remainder.
   assign shifted = {rem_q, dvd_q[WIDTH-1]};

   // Trial subtraction: low WIDTH bits + ~divisor + 1.
   assign op_b     = ~dvs_q;
   assign gen      = shifted[WIDTH-1:0] & op_b;
   assign prop     = shifted[WIDTH-1:0] ^ op_b;
   assign carry[0] = 1'b1;

   // Lookahead inside each 4-bit group, group carries ripple.
   for (genvar g = 0; g < NG; g++) begin : g_cla
      localparam int B = 4 * g;
      logic       c0;
      logic [3:0] p;
      logic [3:0] k;

      assign c0 = carry[B];
      assign p  = prop[B +: 4];
      assign k  = gen[B +: 4];

      assign carry[B+1] = k[0]
                        | (p[0] & c0);
      assign carry[B+2] = k[1]
                        | (p[1] & k[0])
                        | (p[1] & p[0] & c0);
      assign carry[B+3] = k[2]
                        | (p[2] & k[1])
                        | (p[2] & p[1] & k[0])
                        | (p[2] & p[1] & p[0] & c0);
      assign carry[B+4] = k[3]
                        | (p[3] & k[2])
                        | (p[3] & p[2] & k[1])
                        | (p[3] & p[2] & p[1] & k[0])
                        | (p[3] & p[2] & p[1] & p[0] & c0);
   end

   assign diff = prop ^ carry[WIDTH-1:0];

   // The top partial-remainder bit meets an inverted-zero divisor bit
   // (i.e. 1), so its carry-out is shifted[WIDTH] | carry[WIDTH].
   // Borrow is the inverse of that carry-out.
   assign no_borrow = shifted[WIDTH] | carry[WIDTH];

   // On restore shifted[WIDTH] is 0, so the low bits hold the full value.
   assign rem_nx = no_borrow ? diff : shifted[WIDTH-1:0];
   assign dvd_nx = {dvd_q[WIDTH-2:0], no_borrow};

   assign accept = start && (state != CALC);
   assign last   = (cnt == CW'(WIDTH - 1));

   assign busy = (state == CALC);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         rem_q       <= '0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (accept) begin
                  dvd_q       <= dividend;
                  dvs_q       <= divisor;
                  rem_q       <= '0;
                  cnt         <= '0;
                  div_by_zero <= 1'b0;
                  state       <= CALC;
               end else begin
                  state <= IDLE;
               end
            end
            CALC: begin
               rem_q <= rem_nx;
               dvd_q <= dvd_nx;
               cnt   <= cnt + CW'(1);
               if (last) begin
                  // A zero divisor never borrows: quotient fills with
                  // ones and the remainder collects the dividend.
                  quotient    <= dvd_nx;
                  remainder   <= rem_nx;
                  div_by_zero <= (dvs_q == '0);
                  state       <= DONE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
